// File: rtl/uTPU_pkg.sv
// Shared uTPU definitions: link widths and the result streamer state encoding.
// The width check is evaluated wherever a module folds it into its parameters.
package uTPU_pkg;

    localparam int unsigned BUFFER_WORD_SIZE = 16;
    localparam int unsigned FIFO_DATA_WIDTH  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StReadReq,
        StReadWait,
        StSendLo,
        StSendHi,
        StDone
    } streamer_state_e;

    // Returns 1 when a buffer word is exactly two bytes; otherwise divides by zero at elaboration.
    function automatic int unsigned widths_ok(int unsigned word_w, int unsigned byte_w);
        return 32'd1 / ((word_w == 2 * byte_w) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/result_streamer_word_serializer.sv
// Word latch feeding the TX FIFO one byte at a time, low byte first.
// A byte is written only while active and the FIFO has room.
module word_serializer
    import uTPU_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = BUFFER_WORD_SIZE,
    parameter int unsigned BYTE_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] load_data,
    input  logic                  active,
    input  logic                  sel_hi,
    input  logic                  fifo_full,
    output logic                  fifo_we,
    output logic [BYTE_WIDTH-1:0] fifo_wdata
);

    logic [WORD_WIDTH-1:0] word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= load_data;
        end
    end

    assign fifo_we    = active && !fifo_full;
    assign fifo_wdata = sel_hi ? word_q[WORD_WIDTH-1:BYTE_WIDTH] : word_q[BYTE_WIDTH-1:0];

endmodule

// File: rtl/result_streamer.sv
// Reads a run of unified-buffer words and streams them to the TX FIFO as bytes.
// The FSM owns address, remaining count and read-latency wait; bytes go via word_serializer.
module result_streamer
    import uTPU_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE      = 1024,
    parameter int unsigned ADDRESS_SIZE     = $clog2(BUFFER_SIZE),
    parameter int unsigned BUFFER_WORD_SIZE = uTPU_pkg::BUFFER_WORD_SIZE,
    parameter int unsigned FIFO_DATA_WIDTH  = uTPU_pkg::FIFO_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH      = ADDRESS_SIZE + 1,
    parameter int unsigned READ_LATENCY     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDRESS_SIZE-1:0]     base_addr,
    input  logic [COUNT_WIDTH-1:0]      word_count,
    output logic                        busy,
    output logic                        done,
    output logic                        buf_re,
    output logic [ADDRESS_SIZE-1:0]     buf_addr,
    input  logic [BUFFER_WORD_SIZE-1:0] buf_rdata,
    output logic                        fifo_we,
    output logic [FIFO_DATA_WIDTH-1:0]  fifo_wdata,
    input  logic                        fifo_full
);

    localparam int unsigned ByteWidth =
        FIFO_DATA_WIDTH * widths_ok(BUFFER_WORD_SIZE, FIFO_DATA_WIDTH);
    localparam int unsigned WaitWidth = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDRESS_SIZE-1:0] LastAddr = ADDRESS_SIZE'(BUFFER_SIZE - 1);

    streamer_state_e        state_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [COUNT_WIDTH-1:0]  remaining_q;
    logic [WaitWidth-1:0]    wait_q;

    logic load;
    logic send_active;
    logic sel_hi;

    assign load        = (state_q == StReadWait) && (wait_q == '0) && !abort;
    assign sel_hi      = (state_q == StSendHi);
    // Abort and reset both suppress the strobes in the cycle they are asserted.
    assign send_active = ((state_q == StSendLo) || (state_q == StSendHi)) && !abort && !rst;

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign buf_re   = (state_q == StReadReq) && !abort && !rst;
    assign buf_addr = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            wait_q      <= '0;
        end else if (abort && (state_q != StIdle)) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr_q      <= base_addr;
                            remaining_q <= word_count;
                            state_q     <= StReadReq;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StReadReq: begin
                    wait_q  <= WaitWidth'(READ_LATENCY - 1);
                    state_q <= StReadWait;
                end
                StReadWait: begin
                    if (wait_q == '0) begin
                        state_q <= StSendLo;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StSendLo: begin
                    if (fifo_we) begin
                        state_q <= StSendHi;
                    end
                end
                StSendHi: begin
                    if (fifo_we) begin
                        if (remaining_q == COUNT_WIDTH'(1)) begin
                            state_q <= StDone;
                        end else begin
                            remaining_q <= remaining_q - 1'b1;
                            addr_q      <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
                            state_q     <= StReadReq;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    word_serializer #(
        .WORD_WIDTH(BUFFER_WORD_SIZE),
        .BYTE_WIDTH(ByteWidth)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (buf_rdata),
        .active    (send_active),
        .sel_hi    (sel_hi),
        .fifo_full (fifo_full),
        .fifo_we   (fifo_we),
        .fifo_wdata(fifo_wdata)
    );

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: a byte/address scoreboard derived from buffer contents,
// checked every cycle, plus literal cycle-timing and byte expectations per scenario.
module tb_result_streamer;

    localparam int unsigned AW        = 10;
    localparam int unsigned CW        = 11;
    localparam int          RunCycles = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic          busy, done, buf_re, fifo_we;
    logic [AW-1:0] buf_addr;
    logic [15:0]   buf_rdata = '0;
    logic [7:0]    fifo_wdata;
    logic          fifo_full = 1'b0;

    result_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .buf_re    (buf_re),
        .buf_addr  (buf_addr),
        .buf_rdata (buf_rdata),
        .fifo_we   (fifo_we),
        .fifo_wdata(fifo_wdata),
        .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    int          cyc = 0;
    int          t0 = 0;
    bit          logging = 1'b0;
    bit          done_seen = 1'b0;
    bit          done_allowed = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] we_mask, re_mask, done_mask, busy_mask;
    logic [7:0]  exp_bytes[$];
    int          exp_addr[$];
    logic [7:0]  wr_bytes[$];
    int          rd_addrs[$];

    // Buffer with one cycle of read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (buf_re) buf_rdata <= mem[buf_addr];
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (logging && rel >= 0 && rel < 64) begin
            we_mask[rel]   = fifo_we;
            re_mask[rel]   = buf_re;
            done_mask[rel] = done;
            busy_mask[rel] = busy;
        end
        if (fifo_we) begin
            check("we_while_full", fifo_full, 0);
            if (!fifo_full) begin
                check("byte_pending", exp_bytes.size() > 0, 1);
                if (exp_bytes.size() > 0) check("byte", fifo_wdata, exp_bytes.pop_front());
                wr_bytes.push_back(fifo_wdata);
            end
        end
        if (buf_re) begin
            check("read_pending", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) check("read_addr", buf_addr, exp_addr.pop_front());
            rd_addrs.push_back(int'(buf_addr));
        end
        if (done) begin
            done_seen = 1'b1;
            check("done_allowed", done_allowed, 1);
            check("done_bytes_left", exp_bytes.size(), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int base, input int count, input int ff_from, input int ff_to,
                           input int abort_rel, input int rst_rel, input bit stray);
        exp_bytes.delete();
        exp_addr.delete();
        wr_bytes.delete();
        rd_addrs.delete();
        for (int i = 0; i < count; i++) begin
            int a;
            a = (base + i) % 1024;
            exp_addr.push_back(a);
            exp_bytes.push_back(mem[a][7:0]);
            exp_bytes.push_back(mem[a][15:8]);
        end
        we_mask = '0;
        re_mask = '0;
        done_mask = '0;
        busy_mask = '0;
        done_seen = 1'b0;
        done_allowed = (abort_rel < 0) && (rst_rel < 0);
        t0 = cyc;
        logging = 1'b1;
        for (int r = 0; r < RunCycles; r++) begin
            start      = (r == 0) || (stray && (r == 2 || r == 4));
            base_addr  = AW'(base);
            word_count = (r == 0) ? CW'(count) : CW'(5);
            fifo_full  = (r >= ff_from) && (r <= ff_to);
            abort      = (r == abort_rel);
            rst        = (r == rst_rel);
            if (abort || rst) begin
                exp_bytes.delete();
                exp_addr.delete();
            end
            tick();
        end
        start = 1'b0;
        fifo_full = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
        logging = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37 + 11);
        mem[5]    = 16'hBEEF;
        mem[6]    = 16'h1234;
        mem[1023] = 16'hA55A;
        mem[0]    = 16'h0F0F;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_buf_re", buf_re, 0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_fifo_we", fifo_we, 0);
        check("rst_fifo_wdata", fifo_wdata, 0);
        rst = 1'b0;
        tick();

        // Two words, no backpressure.
        run_cmd(5, 2, -1, -1, -1, -1, 1'b0);
        check("t1_we_cycles", we_mask, 64'h198);
        check("t1_done_cycle", done_mask, 64'h200);
        check("t1_busy_cycles", busy_mask, 64'h3FE);
        check("t1_read_cycles", re_mask, 64'h22);
        check("t1_nbytes", wr_bytes.size(), 4);
        check("t1_b0", wr_bytes[0], 8'hEF);
        check("t1_b1", wr_bytes[1], 8'hBE);
        check("t1_b2", wr_bytes[2], 8'h34);
        check("t1_b3", wr_bytes[3], 8'h12);

        // FIFO full for cycles 3-6, stray starts while busy.
        run_cmd(5, 2, 3, 6, -1, -1, 1'b1);
        check("t2_we_cycles", we_mask, 64'h1980);
        check("t2_done_cycle", done_mask, 64'h2000);
        check("t2_busy_cycles", busy_mask, 64'h3FFE);
        check("t2_nbytes", wr_bytes.size(), 4);
        check("t2_b0", wr_bytes[0], 8'hEF);
        check("t2_b3", wr_bytes[3], 8'h12);

        // Address wrap from the last buffer word.
        run_cmd(1023, 2, -1, -1, -1, -1, 1'b0);
        check("t3_nreads", rd_addrs.size(), 2);
        check("t3_addr0", rd_addrs[0], 1023);
        check("t3_addr1", rd_addrs[1], 0);
        check("t3_b0", wr_bytes[0], 8'h5A);
        check("t3_b1", wr_bytes[1], 8'hA5);
        check("t3_b2", wr_bytes[2], 8'h0F);
        check("t3_done", done_seen, 1);

        // Zero-length command.
        run_cmd(7, 0, -1, -1, -1, -1, 1'b0);
        check("t4_no_reads", re_mask, 0);
        check("t4_no_writes", we_mask, 0);
        check("t4_done_cycle", done_mask, 64'h2);

        // Abort during the second word's high byte.
        run_cmd(40, 3, -1, -1, 8, -1, 1'b0);
        check("t5_we_cycles", we_mask, 64'h98);
        check("t5_no_done", done_seen, 0);
        check("t5_idle_after", busy_mask[9], 0);
        check("t5_nbytes", wr_bytes.size(), 3);
        run_cmd(20, 1, -1, -1, -1, -1, 1'b0);
        check("t5b_we_cycles", we_mask, 64'h18);
        check("t5b_done_cycle", done_mask, 64'h20);

        // Reset during the first SEND_LO.
        run_cmd(5, 2, -1, -1, -1, 3, 1'b0);
        check("t6_no_writes", we_mask, 0);
        check("t6_no_done", done_seen, 0);
        check("t6_busy", busy, 0);
        check("t6_buf_addr", buf_addr, 0);
        check("t6_fifo_wdata", fifo_wdata, 0);
        check("t6_buf_re", buf_re, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
Response-path reader for the uTPU host link: the inverse of the controller's byte-to-instruction assembly path. On a command, it reads a contiguous run of 16-bit words from the unified buffer. Each word is split into two bytes, low byte first, and pushed into the TX FIFO that feeds the UART transmitter. Backpressure comes from the FIFO full flag. It sits between unified_buffer's read port and fifo_tx's write port, and the top controller drives it during FETCH operations.

Parameters:
BUFFER_SIZE, 1024, number of words in the unified buffer
ADDRESS_SIZE, $clog2(BUFFER_SIZE), buffer address width
BUFFER_WORD_SIZE, 16, buffer word width; must equal 2*FIFO_DATA_WIDTH
FIFO_DATA_WIDTH, 8, TX FIFO / UART byte width
COUNT_WIDTH, ADDRESS_SIZE+1, width of word_count (allows a full-buffer dump)
READ_LATENCY, 1, cycles from buf_re to valid buf_rdata (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle command strobe; sampled only in IDLE
abort  input  1  cancel current transfer
base_addr  input  ADDRESS_SIZE  first word address, latched on start
word_count  input  COUNT_WIDTH  number of words to send, latched on start
busy  output  1  high from the cycle after an accepted start through the DONE cycle
done  output  1  one-cycle pulse when the final byte has been written
buf_re  output  1  buffer read enable
buf_addr  output  ADDRESS_SIZE  buffer read address
buf_rdata  input  BUFFER_WORD_SIZE  buffer read data
fifo_we  output  1  TX FIFO write enable
fifo_wdata  output  FIFO_DATA_WIDTH  byte to FIFO
fifo_full  input  1  TX FIFO full flag

Behaviour:
- Reset: state=IDLE; busy=0, done=0, buf_re=0, buf_addr=0, fifo_we=0, fifo_wdata=0; internal address, remaining count, word latch and wait counter all cleared. Reset mid-transfer has the same effect: no further writes, no done.
- States: IDLE, READ_REQ, READ_WAIT, SEND_LO, SEND_HI, DONE.
- IDLE:
  - start=1 and word_count!=0 -> latch base_addr and word_count -> READ_REQ.
  - start=1 and word_count==0 -> DONE (done pulses next cycle, no buffer reads).
- READ_REQ: buf_re=1, buf_addr=current address, for exactly one cycle -> READ_WAIT.
- READ_WAIT: stays READ_LATENCY cycles. In the last cycle it captures buf_rdata into the word latch -> SEND_LO.
- SEND_LO: fifo_wdata=word[FIFO_DATA_WIDTH-1:0]; fifo_we = !fifo_full (combinational).
  - fifo_full=1: hold state and data.
  - Otherwise -> SEND_HI.
- SEND_HI: same handshake with word[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH]. On a successful write:
  - remaining==1 -> DONE.
  - Otherwise decrement remaining, address = (address+1) mod BUFFER_SIZE (wraps 1023->0) -> READ_REQ.
- A byte counts as transferred only in a cycle with fifo_we=1 and fifo_full=0; fifo_we is never asserted while fifo_full=1.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- Throughput: with no backpressure and READ_LATENCY=1, 4 cycles per word. The first fifo_we falls 3 cycles after the start cycle.
- start while not IDLE: ignored.
- abort=1 in any non-IDLE state: -> IDLE next cycle, no done pulse, buf_re/fifo_we deasserted that same cycle. abort takes priority over start and over an in-progress write.
- abort in IDLE: no effect.
- word_count > BUFFER_SIZE: the address wraps and rereads words; this is legal.
- buf_re is high only in READ_REQ; the buffer data is not sampled outside READ_WAIT.

Decomposition:
- Shared package uTPU_pkg: streamer state enum (streamer_state_e) and the BUFFER_WORD_SIZE/FIFO_DATA_WIDTH defaults shared with unified_buffer and the fifos.
- The package also holds an elaboration-time check that BUFFER_WORD_SIZE == 2*FIFO_DATA_WIDTH.
- One natural sub-module: word_serializer (word latch plus LO/HI byte select with the full handshake). The FSM, address and count logic stay in result_streamer.

Test Plan:
- base=5, count=2, mem[5]=0xBEEF, mem[6]=0x1234, fifo_full=0, start at cycle 0 -> FIFO bytes EF,BE,34,12 at cycles 3,4,7,8; done at cycle 9; busy high cycles 1-9.
- Same as above, fifo_full=1 for cycles 3-6 -> fifo_we stays low while full, EF is written at cycle 7, byte order unchanged, no byte duplicated or dropped.
- base=1023, count=2, mem[1023]=0xA55A, mem[0]=0x0F0F -> buf_addr 1023 then 0; bytes 5A,A5,0F,0F.
- count=0, start -> no buf_re, no fifo_we, done at cycle 1.
- count=3, abort asserted during the second word's SEND_HI -> that byte is not written, returns to IDLE, no done; a following start with count=1 completes normally.
- rst asserted during SEND_LO -> all outputs go to reset values next cycle; start pulses during busy are ignored (the write count equals 2*word_count of the first command only).
